// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: mode encodings.
package univ_reg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage : univ_reg_pkg

// File: rtl/univ_reg_next.sv
// Combinational next-value and next-flag logic for the universal register.
// Given the current contents and the selected mode, produces what the
// register and its carry/shift-out flag become on the next enabled edge.
module univ_reg_next
   import univ_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  q,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_l,
   input  logic              sin_r,
   output logic [WIDTH-1:0]  q_next,
   output logic              co_next
);

   // One bit wider than q so the carry/borrow falls out of the top bit
   // without ever widening the register itself.
   logic [WIDTH:0] w_inc;
   logic [WIDTH:0] w_dec;

   assign w_inc = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
   assign w_dec = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

   // Select next contents and flag from the operating mode.
   always_comb begin
      // NOTE: defaults come first so no path through the case leaves an
      // output unassigned, which would otherwise infer a latch.
      q_next  = q;
      co_next = 1'b0;
      case (mode)
         MODE_HOLD: begin
            q_next = q;
         end
         MODE_LOAD: begin
            q_next = d;
         end
         MODE_SHL: begin
            q_next  = {q[WIDTH-2:0], sin_r};
            co_next = q[WIDTH-1];
         end
         MODE_SHR: begin
            q_next  = {sin_l, q[WIDTH-1:1]};
            co_next = q[0];
         end
         MODE_ROL: begin
            q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         end
         MODE_ROR: begin
            q_next = {q[0], q[WIDTH-1:1]};
         end
         MODE_INC: begin
            q_next  = w_inc[WIDTH-1:0];
            co_next = w_inc[WIDTH];
         end
         MODE_DEC: begin
            q_next  = w_dec[WIDTH-1:0];
            co_next = w_dec[WIDTH];
         end
         default: begin
            q_next  = q;
            co_next = 1'b0;
         end
      endcase
   end

endmodule : univ_reg_next

// File: rtl/univ_reg.sv
// Universal register: WIDTH-bit storage with asynchronous clear,
// synchronous preset, clock enable and hold/load/shift/rotate/count modes.
// Priority at each edge is clear > preset > en.
module univ_reg
   import univ_reg_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              preset,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_r,
   input  logic              sin_l,
   output logic [WIDTH-1:0]  q,
   output logic              sout_l,
   output logic              sout_r,
   output logic              co
);

   logic [WIDTH-1:0] r_q;
   logic             r_co;
   logic [WIDTH-1:0] w_q_next;
   logic             w_co_next;

   univ_reg_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .mode    (mode),
      .q       (r_q),
      .d       (d),
      .sin_l   (sin_l),
      .sin_r   (sin_r),
      .q_next  (w_q_next),
      .co_next (w_co_next)
   );

   // State register: async clear, then sync preset, then enabled mode update.
   always_ff @(posedge clk or posedge clear) begin
      // NOTE: non-blocking assignments so both flops sample pre-edge values.
      if (clear) begin
         r_q  <= RESET_VAL;
         r_co <= 1'b0;
      end else if (preset) begin
         r_q  <= PRESET_VAL;
         r_co <= 1'b0;
      end else if (en) begin
         r_q  <= w_q_next;
         r_co <= w_co_next;
      end
   end

   assign q      = r_q;
   assign co     = r_co;
   assign sout_l = r_q[WIDTH-1];
   assign sout_r = r_q[0];

   // An unknown mode while enabled would corrupt the register silently.
   a_mode_known: assert property (@(posedge clk) disable iff (clear)
      en |-> !$isunknown(mode));

endmodule : univ_reg

// File: tb/tb_univ_reg.sv
// Directed testbench for univ_reg (WIDTH=8, RESET_VAL=00, PRESET_VAL=FF).
module tb_univ_reg;
   import univ_reg_pkg::*;

   logic       clk;
   logic       clear;
   logic       preset;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_r;
   logic       sin_l;
   logic [7:0] q;
   logic       sout_l;
   logic       sout_r;
   logic       co;

   int n_pass;
   int n_total;

   univ_reg #(
      .WIDTH      (8),
      .RESET_VAL  (8'h00),
      .PRESET_VAL (8'hFF)
   ) dut (
      .clk    (clk),
      .clear  (clear),
      .preset (preset),
      .en     (en),
      .mode   (mode),
      .d      (d),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .q      (q),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .co     (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] val);
      en = 1'b1; mode = MODE_LOAD; d = val;
      step();
   endtask

   task automatic test_reset();
      #3;
      n_total++;
      if ({co, q} !== 9'h000) $display("FAIL reset_state: co,q=%h expected 000", {co, q});
      else n_pass++;
      n_total++;
      if ({sout_l, sout_r} !== 2'b00) $display("FAIL reset_sout: %b expected 00", {sout_l, sout_r});
      else n_pass++;
      step();
      n_total++;
      if ({co, q} !== 9'h000) $display("FAIL reset_held: co,q=%h expected 000", {co, q});
      else n_pass++;
      clear = 1'b0;
   endtask

   task automatic test_async_clear();
      load(8'h5A);
      n_total++;
      if (q !== 8'h5A) $display("FAIL clr_load: q=%h expected 5a", q);
      else n_pass++;
      en = 1'b0;
      #2 clear = 1'b1;
      #1;
      n_total++;
      if ({co, q} !== 9'h000) $display("FAIL clr_async: co,q=%h expected 000", {co, q});
      else n_pass++;
      #1 clear = 1'b0;
      load(8'h3C);
      n_total++;
      if ({co, q} !== 9'h03C) $display("FAIL clr_release_load: co,q=%h expected 03c", {co, q});
      else n_pass++;
   endtask

   task automatic test_preset();
      preset = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'h12;
      step();
      n_total++;
      if ({co, q} !== 9'h0FF) $display("FAIL preset_over_load: co,q=%h expected 0ff", {co, q});
      else n_pass++;
      #2 clear = 1'b1;
      #1;
      n_total++;
      if (q !== 8'h00) $display("FAIL clear_over_preset: q=%h expected 00", q);
      else n_pass++;
      step();
      n_total++;
      if (q !== 8'h00) $display("FAIL clear_holds_preset: q=%h expected 00", q);
      else n_pass++;
      clear = 1'b0; preset = 1'b0;
   endtask

   task automatic test_shift();
      load(8'h81);
      mode = MODE_SHL; sin_r = 1'b0;
      step();
      n_total++;
      if ({co, q} !== 9'h102) $display("FAIL shl: co,q=%h expected 102", {co, q});
      else n_pass++;
      n_total++;
      if ({sout_l, sout_r} !== 2'b00) $display("FAIL shl_sout: %b expected 00", {sout_l, sout_r});
      else n_pass++;
      mode = MODE_SHR; sin_l = 1'b1;
      step();
      n_total++;
      if ({co, q} !== 9'h081) $display("FAIL shr: co,q=%h expected 081", {co, q});
      else n_pass++;
      n_total++;
      if ({sout_l, sout_r} !== 2'b11) $display("FAIL shr_sout: %b expected 11", {sout_l, sout_r});
      else n_pass++;
      // Shift a 1 out of bit 0 to see the SHR flag set.
      step();
      n_total++;
      if ({co, q} !== 9'h1C0) $display("FAIL shr_co: co,q=%h expected 1c0", {co, q});
      else n_pass++;
      sin_l = 1'b0;
   endtask

   task automatic test_rotate();
      load(8'h81);
      mode = MODE_ROL;
      step();
      n_total++;
      if ({co, q} !== 9'h003) $display("FAIL rol: co,q=%h expected 003", {co, q});
      else n_pass++;
      mode = MODE_ROR;
      step();
      n_total++;
      if ({co, q} !== 9'h081) $display("FAIL ror1: co,q=%h expected 081", {co, q});
      else n_pass++;
      step();
      n_total++;
      if ({co, q} !== 9'h0C0) $display("FAIL ror2: co,q=%h expected 0c0", {co, q});
      else n_pass++;
   endtask

   task automatic test_count();
      load(8'hFE);
      mode = MODE_INC;
      step();
      n_total++;
      if ({co, q} !== 9'h0FF) $display("FAIL inc1: co,q=%h expected 0ff", {co, q});
      else n_pass++;
      step();
      n_total++;
      if ({co, q} !== 9'h100) $display("FAIL inc_wrap: co,q=%h expected 100", {co, q});
      else n_pass++;
      mode = MODE_DEC;
      step();
      n_total++;
      if ({co, q} !== 9'h1FF) $display("FAIL dec_wrap: co,q=%h expected 1ff", {co, q});
      else n_pass++;
      en = 1'b0; mode = MODE_LOAD; d = 8'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if ({co, q} !== 9'h1FF) $display("FAIL en_hold_%0d: co,q=%h expected 1ff", i, {co, q});
         else n_pass++;
      end
      en = 1'b1; mode = MODE_DEC;
      step();
      n_total++;
      if ({co, q} !== 9'h0FE) $display("FAIL dec_nowrap: co,q=%h expected 0fe", {co, q});
      else n_pass++;
      mode = MODE_INC;
      step();
      step();
      mode = MODE_HOLD;
      step();
      n_total++;
      if ({co, q} !== 9'h000) $display("FAIL hold_clears_co: co,q=%h expected 000", {co, q});
      else n_pass++;
   endtask

   task automatic test_clear_mid_count();
      load(8'h00);
      mode = MODE_INC;
      for (int i = 0; i < 5; i++) step();
      n_total++;
      if ({co, q} !== 9'h005) $display("FAIL count5: co,q=%h expected 005", {co, q});
      else n_pass++;
      #2 clear = 1'b1;
      #1;
      n_total++;
      if ({co, q} !== 9'h000) $display("FAIL clear_mid_count: co,q=%h expected 000", {co, q});
      else n_pass++;
      #1 clear = 1'b0;
      step();
      step();
      n_total++;
      if ({co, q} !== 9'h002) $display("FAIL count_resume: co,q=%h expected 002", {co, q});
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      clear = 1'b1; preset = 1'b0; en = 1'b0; mode = MODE_HOLD;
      d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
      test_reset();
      test_async_clear();
      test_preset();
      test_shift();
      test_rotate();
      test_count();
      test_clear_mid_count();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_univ_reg
